// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants and prescaler width helper for the GPIO input path
package gpio_pkg;
  localparam int GPIO_N = 15;
  localparam int GPIO_STABLE_DEF = 3;
  localparam int GPIO_PRESCALE_DEF = 1000;
  function automatic int gpio_cnt_w(input int p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction
endpackage

// File: rtl/gpio_input_conditioner_if.sv
// gpio_input_conditioner_if: pin inputs, irq controls and conditioned outputs
interface gpio_input_conditioner_if
  import gpio_pkg::*;
#(parameter int N = GPIO_N);
  logic [N:0] i_pins;
  logic [N:0] i_rise_en;
  logic [N:0] i_fall_en;
  logic [N:0] i_irq_clr;
  logic [N:0] o_data;
  logic [N:0] o_rise;
  logic [N:0] o_fall;
  logic [N:0] o_irq_pending;
  logic o_irq;
  modport master (
    output i_pins, i_rise_en, i_fall_en, i_irq_clr,
    input  o_data, o_rise, o_fall, o_irq_pending, o_irq
  );
  modport slave (
    input  i_pins, i_rise_en, i_fall_en, i_irq_clr,
    output o_data, o_rise, o_fall, o_irq_pending, o_irq
  );
endinterface

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: 2-flop sync, tick-sampled history, debounced level and edge pulses
module gpio_debounce_bit
  import gpio_pkg::*;
#(parameter int STABLE = GPIO_STABLE_DEF) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_pin,
  output logic o_data,
  output logic o_rise,
  output logic o_fall
);
  logic sync1, sync2;
  logic [STABLE-2:0] hist;
  logic [STABLE-1:0] win;
  logic all1, all0;
  assign win = {hist, sync2};
  assign all1 = &win;
  assign all0 = ~|win;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist <= '0;
      o_data <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      sync1 <= i_pin;
      sync2 <= sync1;
      o_rise <= i_tick & all1 & ~o_data;
      o_fall <= i_tick & all0 & o_data;
      if (i_tick) begin
        hist <= win[STABLE-2:0];
        o_data <= all1 | (o_data & ~all0);
      end
    end
endmodule

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: sync + debounce + edge detect for one GPIO port, with
// sticky W1C pending flags built only when GPIO_IN_IRQ_EN is defined.
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int N = GPIO_N,
  parameter int PRESCALE = GPIO_PRESCALE_DEF,
  parameter int STABLE = GPIO_STABLE_DEF
) (
  input logic i_clk,
  input logic i_rst_n,
  gpio_input_conditioner_if.slave bus
);
  localparam int CW = gpio_cnt_w(PRESCALE);
  logic [CW-1:0] cnt;
  logic tick;
  logic [N:0] data, rise, fall;
  assign tick = cnt == CW'(PRESCALE - 1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  genvar i;
  generate
    for (i = 0; i <= N; i++) begin : g_bit
      gpio_debounce_bit #(.STABLE(STABLE)) u_bit (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_tick(tick),
        .i_pin(bus.i_pins[i]),
        .o_data(data[i]),
        .o_rise(rise[i]),
        .o_fall(fall[i])
      );
    end
  endgenerate
  assign bus.o_data = data;
  assign bus.o_rise = rise;
  assign bus.o_fall = fall;
`ifdef GPIO_IN_IRQ_EN
  logic [N:0] pend;
  // set uses the registered pulses so a clear landing in the pulse cycle cannot drop the event
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) pend <= '0;
    else pend <= (pend & ~bus.i_irq_clr) | (rise & bus.i_rise_en) | (fall & bus.i_fall_en);
  assign bus.o_irq_pending = pend;
  assign bus.o_irq = |pend;
`else
  logic unused_irq;
  assign unused_irq = &{1'b0, bus.i_rise_en, bus.i_fall_en, bus.i_irq_clr};
  assign bus.o_irq_pending = '0;
  assign bus.o_irq = 1'b0;
`endif
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner: scoreboard bench; PRESCALE=1 and PRESCALE=4 instances, STABLE=3
module tb_gpio_input_conditioner;
`ifdef GPIO_IN_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  typedef struct {
    logic [15:0] d, r, f, p;
    logic q;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int edges = 0;
  gpio_input_conditioner_if #(.N(15)) b1();
  gpio_input_conditioner_if #(.N(15)) b4();
  gpio_input_conditioner #(.N(15), .PRESCALE(1), .STABLE(3)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b1.slave)
  );
  gpio_input_conditioner #(.N(15), .PRESCALE(4), .STABLE(3)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b4.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edges <= rst_n ? edges + 1 : 0;

  task step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic exp_t mk(logic [15:0] d, logic [15:0] r, logic [15:0] f, logic [15:0] p);
    exp_t x;
    x.d = d; x.r = r; x.f = f; x.p = IRQ ? p : 16'h0; x.q = IRQ && (p != 0);
    return x;
  endfunction

  task test_reset();
    rst_n = 1'b0;
    b1.i_pins = 16'hFFFF; b1.i_rise_en = '0; b1.i_fall_en = '0; b1.i_irq_clr = '0;
    b4.i_pins = '0; b4.i_rise_en = '0; b4.i_fall_en = '0; b4.i_irq_clr = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({b1.o_data, b1.o_rise, b1.o_fall, b1.o_irq_pending, b1.o_irq,
           b4.o_data, b4.o_rise, b4.o_fall, b4.o_irq_pending, b4.o_irq} !== '0) begin
        errors++;
        $display("FAIL reset_hold k=%0d got d1=%h r1=%h d4=%h required all 0", k, b1.o_data, b1.o_rise, b4.o_data);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++)
      sb.push_back(mk(k >= 4 ? 16'hFFFF : 16'h0, k == 4 ? 16'hFFFF : 16'h0, 16'h0, 16'h0));
    for (int k = 0; k < 7; k++) begin
      step();
      e = sb.pop_front();
      checks++;
      if ({b1.o_data, b1.o_rise, b1.o_fall, b1.o_irq_pending, b1.o_irq} !== {e.d, e.r, e.f, e.p, e.q}) begin
        errors++;
        $display("FAIL reset_release k=%0d got d=%h r=%h f=%h p=%h q=%b required d=%h r=%h f=%h p=%h q=%b",
                 k, b1.o_data, b1.o_rise, b1.o_fall, b1.o_irq_pending, b1.o_irq, e.d, e.r, e.f, e.p, e.q);
      end
    end
    b1.i_pins = '0;
    repeat (10) step();
  endtask

  task test_glitch(input int w);
    for (int k = 0; k < 12; k++)
      sb.push_back(mk((w >= 3 && k >= 4 && k < 4 + w) ? 16'h0020 : 16'h0,
                      (w >= 3 && k == 4) ? 16'h0020 : 16'h0,
                      (w >= 3 && k == 4 + w) ? 16'h0020 : 16'h0, 16'h0));
    for (int k = 0; k < 12; k++) begin
      b1.i_pins = (k < w) ? 16'h0020 : 16'h0;
      step();
      e = sb.pop_front();
      checks++;
      if ({b1.o_data, b1.o_rise, b1.o_fall, b1.o_irq_pending, b1.o_irq} !== {e.d, e.r, e.f, e.p, e.q}) begin
        errors++;
        $display("FAIL glitch_w%0d k=%0d got d=%h r=%h f=%h required d=%h r=%h f=%h",
                 w, k, b1.o_data, b1.o_rise, b1.o_fall, e.d, e.r, e.f);
      end
    end
  endtask

  task test_prescale();
    int hit, ph;
    logic pulse;
    for (int dir = 1; dir >= 0; dir--) begin
      hit = -1; ph = -1; pulse = 1'b0;
      b4.i_pins = dir[0] ? 16'h0001 : 16'h0;
      for (int k = 0; k < 20; k++) begin
        step();
        if (hit < 0 && b4.o_data[0] == dir[0]) begin
          hit = k; ph = edges % 4; pulse = dir[0] ? b4.o_rise[0] : b4.o_fall[0];
        end
      end
      checks++;
      if (hit < 9 || hit > 14) begin
        errors++;
        $display("FAIL prescale_latency dir=%0d got edge=%0d required 9..14", dir, hit);
      end
      checks++;
      if (ph !== 0) begin
        errors++;
        $display("FAIL prescale_tick_phase dir=%0d got phase=%0d required 0", dir, ph);
      end
      checks++;
      if (pulse !== 1'b1) begin
        errors++;
        $display("FAIL prescale_pulse dir=%0d got %b required 1", dir, pulse);
      end
    end
  endtask

  task test_irq();
    b1.i_rise_en = 16'h0008; b1.i_fall_en = 16'h0;
    for (int k = 0; k < 16; k++)
      sb.push_back(mk((k >= 4 && k < 10) ? 16'h0008 : 16'h0, k == 4 ? 16'h0008 : 16'h0,
                      k == 10 ? 16'h0008 : 16'h0, (k >= 5 && k < 14) ? 16'h0008 : 16'h0));
    for (int k = 0; k < 16; k++) begin
      b1.i_pins = (k < 6) ? 16'h0008 : 16'h0;
      b1.i_irq_clr = (k == 14) ? 16'h0008 : 16'h0;
      step();
      e = sb.pop_front();
      checks++;
      if ({b1.o_data, b1.o_rise, b1.o_fall, b1.o_irq_pending, b1.o_irq} !== {e.d, e.r, e.f, e.p, e.q}) begin
        errors++;
        $display("FAIL irq k=%0d got d=%h r=%h f=%h p=%h q=%b required d=%h r=%h f=%h p=%h q=%b",
                 k, b1.o_data, b1.o_rise, b1.o_fall, b1.o_irq_pending, b1.o_irq, e.d, e.r, e.f, e.p, e.q);
      end
    end
    b1.i_irq_clr = '0;
  endtask

  task test_collision();
    for (int k = 0; k < 10; k++)
      sb.push_back(mk(k >= 4 ? 16'h0080 : 16'h0, k == 4 ? 16'h0080 : 16'h0, 16'h0,
                      k >= 5 ? 16'h0080 : 16'h0));
    for (int k = 0; k < 10; k++) begin
      b1.i_pins = 16'h0080;
      b1.i_rise_en = (k < 6) ? 16'h0080 : 16'h0;
      b1.i_irq_clr = (k == 5) ? 16'h0080 : 16'h0;
      step();
      e = sb.pop_front();
      checks++;
      if ({b1.o_data, b1.o_rise, b1.o_fall, b1.o_irq_pending, b1.o_irq} !== {e.d, e.r, e.f, e.p, e.q}) begin
        errors++;
        $display("FAIL collision k=%0d got d=%h r=%h p=%h q=%b required d=%h r=%h p=%h q=%b",
                 k, b1.o_data, b1.o_rise, b1.o_irq_pending, b1.o_irq, e.d, e.r, e.p, e.q);
      end
    end
    b1.i_irq_clr = '0;
  endtask

  task test_async_reset();
    b1.i_rise_en = 16'hFFFF;
    b1.i_pins = 16'h0084;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({b1.o_data, b1.o_rise, b1.o_fall, b1.o_irq_pending, b1.o_irq,
         b4.o_data, b4.o_rise, b4.o_fall, b4.o_irq_pending, b4.o_irq} !== '0) begin
      errors++;
      $display("FAIL async_reset_immediate got d1=%h p1=%h q1=%b d4=%h required all 0",
               b1.o_data, b1.o_irq_pending, b1.o_irq, b4.o_data);
    end
    b1.i_pins = '0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) sb.push_back(mk(16'h0, 16'h0, 16'h0, 16'h0));
    for (int k = 0; k < 10; k++) begin
      step();
      e = sb.pop_front();
      checks++;
      if ({b1.o_data, b1.o_rise, b1.o_fall, b1.o_irq_pending, b1.o_irq} !== {e.d, e.r, e.f, e.p, e.q}) begin
        errors++;
        $display("FAIL async_reset_after k=%0d got d=%h r=%h p=%h q=%b required all 0",
                 k, b1.o_data, b1.o_rise, b1.o_irq_pending, b1.o_irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch(2);
    test_glitch(3);
    test_prescale();
    test_irq();
    test_collision();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
- Sits directly downstream of the GPIO port block's received-data output, on the input path of the MIPS soft processor's GPIO subsystem.
- Raw pin levels are asynchronous to i_clk. This block synchronises them, debounces them on a shared prescaled sample tick, and detects rising and falling edges.
- It keeps sticky per-bit interrupt-pending flags that the CPU clears with write-1-to-clear pulses.

Parameters:
- N, 15, MSB index of one port; all bit vectors are [N:0], i.e. N+1 bits.
- PRESCALE, 1000, i_clk cycles per debounce sample tick; legal range 1..65535.
- STABLE, 3, consecutive equal ticks required to accept a new level; legal range 2..8.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_pins  input  N+1  raw pin levels from the GPIO port block's received-data output.
- i_rise_en  input  N+1  per-bit rising-edge interrupt enable.
- i_fall_en  input  N+1  per-bit falling-edge interrupt enable.
- i_irq_clr  input  N+1  write-1-to-clear pulse for the pending flags.
- o_data  output  N+1  debounced level.
- o_rise  output  N+1  one-cycle pulse when a debounced bit goes 0->1.
- o_fall  output  N+1  one-cycle pulse when a debounced bit goes 1->0.
- o_irq_pending  output  N+1  sticky pending flags.
- o_irq  output  1  OR-reduction of o_irq_pending.

Behaviour:
- Reset: one clock i_clk; reset is asynchronous and active-low (i_rst_n). While i_rst_n=0, all registers clear immediately: sync stages, prescaler, history, o_data, o_rise, o_fall, o_irq_pending. o_irq is therefore 0.
- Synchroniser: two flip-flop stages per bit (sync1, sync2). No logic between the stages.
- Prescaler:
  - Counter counts 0..PRESCALE-1 and wraps to 0.
  - tick=1 in the cycle where the count equals PRESCALE-1.
  - With PRESCALE=1, tick is 1 every cycle.
  - Counter width is max(1, clog2(PRESCALE)).
- History:
  - Per bit, a register hist[STABLE-2:0]. On each tick it shifts in sync2.
  - Between ticks, hist and o_data hold.
- Debounced level:
  - On a tick, if {hist, sync2} is all ones, o_data takes 1 at that edge; if all zeros, it takes 0.
  - Otherwise o_data holds its value.
  - Any pulse shorter than STABLE ticks is rejected.
- Latency: with PRESCALE=1, a raw change set up before edge 0 appears on o_data after edge STABLE+1. With STABLE=3 that is edge 4.
- Edge pulses:
  - o_rise and o_fall are registered on the same edge that o_data changes. Each lasts exactly one cycle.
  - They are never both 1 for the same bit.
- Pending flags, per bit:
  - Set term: (rise_pulse & i_rise_en) | (fall_pulse & i_fall_en), taken from the same-edge pulse values.
  - Clear term: i_irq_clr.
  - Next value: (pending & ~clr) | set. Set wins over a simultaneous clear, so no event is lost.
  - Enables gate only the setting of a flag. Dropping an enable does not clear an already-set flag.
- Out of reset:
  - If a pin is held high through reset, o_data rises after debounce and produces o_rise. This is intended; software clears the spurious pending flag.
  - If reset is asserted mid-debounce, the partial history is discarded.

Optional Feature:
- Macro: GPIO_IN_IRQ_EN.
- Defined: the pending flags and o_irq are implemented as described above.
- Undefined: no pending registers are built. o_irq_pending and o_irq are tied to 0, and i_rise_en, i_fall_en and i_irq_clr are ignored. o_data, o_rise and o_fall are unaffected.

Decomposition:
- Shared package gpio_pkg holds:
  - constants GPIO_N=15, GPIO_STABLE_DEF=3, GPIO_PRESCALE_DEF=1000;
  - a function for the prescaler counter width.
- One sub-module, gpio_debounce_bit: sync1, sync2, hist, o_data and the rise/fall pulses for a single bit, with the shared tick as an input.
  - Instantiated as an array [N:0].
  - The top level owns the prescaler and the pending/irq logic.

Test Plan:
- Reset: i_rst_n=0 with i_pins=16'hFFFF, then release. All outputs are 0 during reset. With PRESCALE=1 and STABLE=3, o_data becomes 16'hFFFF 4 cycles after the first edge following release; o_rise=16'hFFFF for exactly one cycle.
- Glitch rejection: PRESCALE=1, STABLE=3, bit 5 pulsed high for 2 cycles -> o_data[5] stays 0 and there is no o_rise[5]. A 3-cycle pulse -> o_data[5]=1 for exactly 3 cycles; o_rise[5] and o_fall[5] each pulse once.
- Prescaled timing: PRESCALE=4, STABLE=3, bit 0 raised -> o_data[0] changes only on a tick edge, between 9 and 14 cycles after the change.
- Interrupts: i_rise_en[3]=1, i_fall_en[3]=0, bit 3 toggled 0->1->0 -> o_irq_pending[3] sets on the rise only and o_irq=1. i_irq_clr[3] pulse -> flag and o_irq return to 0 on the next edge.
- Set/clear collision: i_irq_clr[7]=1 in the same cycle as o_rise[7]=1 with i_rise_en[7]=1 -> o_irq_pending[7] ends as 1.
- Async reset mid-debounce: i_rst_n dropped between clock edges while a rise is half-qualified -> all outputs 0 immediately. After release with pins held low, no o_rise appears.
